// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared types and constants for the add_sub block
//
// Purpose: flag bundle produced by the arithmetic core and the default
// operand width used by add_sub and add_sub_core.
package add_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic carry;     // add: carry-out, sub: borrow
    logic overflow;  // signed overflow
    logic zero;      // result == 0
    logic negative;  // result MSB
  } add_sub_flags_t;

endpackage

// File: rtl/add_sub_core.sv
// rtl/add_sub_core.sv - combinational single-adder add/subtract with flags
//
// Purpose: computes a+b or a-b modulo 2^WIDTH and the status flags.
// Ports:
//   a, b    in  WIDTH  operands
//   sub     in  1      0 = add, 1 = subtract
//   result  out WIDTH  sum or difference
//   flags   out 4      carry/borrow, overflow, zero, negative
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output add_sub_flags_t   flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtraction is a + ~b + 1, so one adder serves both operations.
  assign b_eff  = b ^ {WIDTH{sub}};
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign result = sum[WIDTH-1:0];

  // Raw carry of a + ~b + 1 is the inverse of borrow, hence the XOR.
  assign flags.carry    = sum[WIDTH] ^ sub;
  // Overflow when the effective operands share a sign and the result does not.
  assign flags.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (result[WIDTH-1] != a[WIDTH-1]);
  assign flags.zero     = (result == '0);
  assign flags.negative = result[WIDTH-1];

endmodule

// File: rtl/add_sub.sv
// rtl/add_sub.sv - adder/subtractor with registered result and status
//
// Purpose: combinational add/sub with flags plus a one-cycle registered copy.
// Optional sticky flags are built when ADD_SUB_STICKY_EN is defined.
// Ports:
//   clk, rst         in   clock, synchronous active-high reset
//   a, b, sub        in   operands and operation select
//   en               in   capture enable for the registered stage
//   result           out  combinational result
//   carry_or_borrow  out  carry (add) or borrow (sub)
//   overflow, zero, negative  out  combinational status
//   result_q, carry_q out registered result and carry/borrow
//   valid_q          out  high the cycle after a capture
//   clr_sticky       in   (ADD_SUB_STICKY_EN) clear sticky flags, wins over set
//   sticky_carry, sticky_ovf  out  (ADD_SUB_STICKY_EN) accumulated flags
module add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             en,
  output logic [WIDTH-1:0] result,
  output logic             carry_or_borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [WIDTH-1:0] result_q,
  output logic             carry_q,
`ifdef ADD_SUB_STICKY_EN
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
`endif
  output logic             valid_q
);

  add_sub_flags_t flags;

  add_sub_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .sub    (sub),
    .result (result),
    .flags  (flags)
  );

  assign carry_or_borrow = flags.carry;
  assign overflow        = flags.overflow;
  assign zero            = flags.zero;
  assign negative        = flags.negative;

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             valid_d;

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = 1'b0;
    if (en) begin
      result_d = result;
      carry_d  = flags.carry;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end

`ifdef ADD_SUB_STICKY_EN
  logic sticky_carry_q, sticky_carry_d;
  logic sticky_ovf_q, sticky_ovf_d;

  always_comb begin
    sticky_carry_d = sticky_carry_q;
    sticky_ovf_d   = sticky_ovf_q;
    if (clr_sticky) begin
      sticky_carry_d = 1'b0;
      sticky_ovf_d   = 1'b0;
    end else if (en) begin
      sticky_carry_d = sticky_carry_q | flags.carry;
      sticky_ovf_d   = sticky_ovf_q | flags.overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
    end else begin
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
    end
  end

  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
`endif

endmodule

// File: tb/tb_add_sub.sv
// tb/tb_add_sub.sv - self-checking bench for add_sub (WIDTH=8)
module tb_add_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0, en = 1'b0;
  logic [7:0] result, result_q;
  logic       carry_or_borrow, overflow, zero, negative, carry_q, valid_q;
`ifdef ADD_SUB_STICKY_EN
  logic       clr_sticky = 1'b0;
  logic       sticky_carry, sticky_ovf;
`endif

  int tests  = 0;
  int failed = 0;

  // Reference state for the registered stage
  int m_rq = 0, m_cq = 0, m_vq = 0;
  int m_sc = 0, m_so = 0;
  // Reference combinational values for the current inputs
  int e_res, e_c, e_ov, e_z, e_n;

  always #5 clk = ~clk;

  add_sub #(.WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .a               (a),
    .b               (b),
    .sub             (sub),
    .en              (en),
    .result          (result),
    .carry_or_borrow (carry_or_borrow),
    .overflow        (overflow),
    .zero            (zero),
    .negative        (negative),
    .result_q        (result_q),
    .carry_q         (carry_q),
`ifdef ADD_SUB_STICKY_EN
    .clr_sticky      (clr_sticky),
    .sticky_carry    (sticky_carry),
    .sticky_ovf      (sticky_ovf),
`endif
    .valid_q         (valid_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference in plain integers: unsigned range for carry/borrow,
  // signed range for overflow.
  task automatic model(input int ia, input int ib, input int isub);
    int sa, sb, sr, full;
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    if (isub != 0) begin
      full = ia - ib;
      e_c  = (ia < ib) ? 1 : 0;
      sr   = sa - sb;
    end else begin
      full = ia + ib;
      e_c  = (full > 255) ? 1 : 0;
      sr   = sa + sb;
    end
    e_res = (full + 256) % 256;
    e_ov  = (sr > 127 || sr < -128) ? 1 : 0;
    e_z   = (e_res == 0) ? 1 : 0;
    e_n   = (e_res >= 128) ? 1 : 0;
  endtask

  // Apply inputs, check combinational outputs, clock once, check registers.
  task automatic step(input int ia, input int ib, input int isub, input int ien,
                      input int irst, input int iclr);
    a   = ia[7:0];
    b   = ib[7:0];
    sub = isub[0];
    en  = ien[0];
    rst = irst[0];
`ifdef ADD_SUB_STICKY_EN
    clr_sticky = iclr[0];
`endif
    #1;
    model(ia, ib, isub);
    check("result",   64'(result),          64'(e_res));
    check("carry",    64'(carry_or_borrow), 64'(e_c));
    check("overflow", 64'(overflow),        64'(e_ov));
    check("zero",     64'(zero),            64'(e_z));
    check("negative", 64'(negative),        64'(e_n));
    @(posedge clk);
    if (irst != 0) begin
      m_rq = 0; m_cq = 0; m_vq = 0; m_sc = 0; m_so = 0;
    end else begin
      if (ien != 0) begin
        m_rq = e_res; m_cq = e_c; m_vq = 1;
      end else begin
        m_vq = 0;
      end
      if (iclr != 0) begin
        m_sc = 0; m_so = 0;
      end else if (ien != 0) begin
        m_sc = m_sc | e_c; m_so = m_so | e_ov;
      end
    end
    #1;
    check("result_q", 64'(result_q), 64'(m_rq));
    check("carry_q",  64'(carry_q),  64'(m_cq));
    check("valid_q",  64'(valid_q),  64'(m_vq));
`ifdef ADD_SUB_STICKY_EN
    check("sticky_carry", 64'(sticky_carry), 64'(m_sc));
    check("sticky_ovf",   64'(sticky_ovf),   64'(m_so));
`endif
  endtask

  initial begin
    // Reset state, including combinational validity during reset
    step(3, 4, 0, 1, 1, 0);
    check("rst_result_q", 64'(result_q), 64'h0);
    check("rst_valid_q",  64'(valid_q),  64'h0);

    // Directed plan and boundaries (inputs remain applied after each step)
    step(15, 10, 0, 1, 0, 0);
    check("plan_15p10", 64'({result, carry_or_borrow, zero}), 64'({8'd25, 1'b0, 1'b0}));
    step(8'hFF, 8'h01, 0, 1, 0, 0);
    check("plan_ffp1", 64'({result, carry_or_borrow, zero}), 64'({8'h00, 1'b1, 1'b1}));
    step(20, 5, 1, 1, 0, 0);
    check("plan_20m5", 64'({result, carry_or_borrow}), 64'({8'd15, 1'b0}));
    step(5, 10, 1, 0, 0, 0);
    check("plan_5m10", 64'({result, carry_or_borrow, negative}), 64'({8'd251, 1'b1, 1'b1}));
    check("hold_result_q", 64'(result_q), 64'd15);
    step(0, 1, 1, 1, 0, 0);
    check("bnd_0m1", 64'({result, carry_or_borrow}), 64'({8'hFF, 1'b1}));
    step(8'h80, 8'h01, 1, 1, 0, 0);
    check("bnd_80m1", 64'({result, overflow, carry_or_borrow}), 64'({8'h7F, 1'b1, 1'b0}));
    step(8'h5A, 8'h5A, 1, 1, 0, 0);
    check("bnd_eq", 64'({result, carry_or_borrow, zero}), 64'({8'h00, 1'b0, 1'b1}));
    step(8'h7F, 8'h01, 0, 1, 0, 0);
    check("plan_7fp1", 64'({overflow, carry_or_borrow}), 64'({1'b1, 1'b0}));
    check("plan_7fp1_q", 64'({result_q, valid_q}), 64'({8'h80, 1'b1}));
    // Reset mid-operation with en high clears the registers on that edge
    step(8'h7F, 8'h01, 0, 1, 1, 0);
    check("plan_rst_q", 64'({result_q, carry_q, valid_q}), 64'h0);

`ifdef ADD_SUB_STICKY_EN
    step(8'hF0, 8'h20, 0, 1, 0, 0);
    step(1, 2, 0, 1, 0, 0);
    step(9, 3, 1, 1, 0, 0);
    check("sticky_hold", 64'(sticky_carry), 64'h1);
    step(8'hF0, 8'h20, 0, 1, 0, 1);
    check("sticky_clr_wins", 64'(sticky_carry), 64'h0);
`endif

    // Randomized traffic with occasional en gaps, resets and clears
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
